fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Shares the single VGA framebuffer write port (`fb_addr`/`fb_data`/`fb_we` into `vga_controller`) between CPU stores and a hardware fill engine. The fill engine is used for screen clear and region fill. The block sits between `cpu` and `vga_controller` in `main`, in the `MAX10_CLK1_50` domain. It grants one write per cycle using round-robin arbitration and drives a registered write port.

## Interface
Parameters:
- `ADDR_W`, 12, framebuffer address width.
- `DATA_W`, 8, framebuffer data width.

Ports:
- `clk50`  in  1  system clock (`MAX10_CLK1_50`).
- `rst`  in  1  reset; synchronous, active-high.
- `cpu_we`  in  1  CPU write request (valid).
- `cpu_addr`  in  ADDR_W  CPU write address.
- `cpu_data`  in  DATA_W  CPU write data.
- `cpu_ready`  out  1  the CPU write is accepted when `cpu_we && cpu_ready`.
- `fill_start`  in  1  single-cycle fill command.
- `fill_base`  in  ADDR_W  first address of the fill.
- `fill_count`  in  ADDR_W+1  number of bytes to write; 0 is legal.
- `fill_value`  in  DATA_W  byte written by the fill.
- `fill_busy`  out  1  the fill engine is active.
- `fill_done`  out  1  one-cycle pulse when a fill completes.
- `fb_addr`  out  ADDR_W  framebuffer write address (registered).
- `fb_data`  out  DATA_W  framebuffer write data (registered).
- `fb_we`  out  1  framebuffer write strobe (registered, one cycle per write).

## Operation
Fill state machine:
- States are IDLE and RUN. `fill_busy = (state == RUN)`.
- In IDLE, `fill_start` latches `ptr <= fill_base`, `rem <= fill_count` and `val <= fill_value`.
  - If `fill_count == 0`, the state stays IDLE, `fill_done` pulses next cycle and no writes are issued.
  - Otherwise the state goes to RUN.
- `fill_start` while in RUN is ignored; parameters are not re-latched.
- In RUN, each cycle with `fill_grant`: write `ptr`/`val`, then `ptr <= ptr + 1` (mod 2^ADDR_W, wraps 0xFFF→0x000) and `rem <= rem - 1`.
- On the grant where `rem == 1`: the state goes to IDLE and `fill_done` is set to 1 for one cycle.

Arbitration:
- `last` is a 1-bit register recording the most recent contended winner (CPU or FILL).
- `cpu_ready = !fill_busy || last == FILL`. It does not depend on `cpu_we`.
- `cpu_grant = cpu_we && cpu_ready`.
- `fill_grant = fill_busy && !cpu_grant`.
- `last` updates only on cycles where `cpu_we && fill_busy`: it is set to the winner.
- Result: under sustained contention, grants strictly alternate. An uncontended requester is granted every cycle.

Output port:
- Each grant registers `fb_addr`/`fb_data` from the winner and sets `fb_we = 1` on the next cycle.
- With no grant, `fb_we = 0` and `fb_addr`/`fb_data` hold their previous values.

## Timing
- Reset values:
  - `fb_we = 0`, `fb_addr = 0`, `fb_data = 0`.
  - `fill_busy = 0`, `fill_done = 0`.
  - `cpu_ready = 1`, `last = FILL` (the CPU wins the first conflict).
  - State = IDLE.
- Latency: grant in cycle t gives `fb_we` in cycle t+1.
- Uncontended fill of N bytes with `fill_start` at cycle 0:
  - `fill_busy` is high for cycles 1..N.
  - `fb_we` is high for cycles 2..N+1.
  - `fill_done` pulses at cycle N+1, coincident with the last `fb_we`.
  - `fill_busy` falls at cycle N+1.
- A new `fill_start` is accepted in the `fill_done` cycle.
- With continuous `cpu_we` during a fill of N bytes, the fill takes 2N cycles (alternating).
- Reset in RUN aborts the fill immediately: no `fill_done` pulse, no further writes. A write already registered is dropped, because `fb_we` is cleared.
- `fill_start` in the same cycle as `rst` is ignored.

## Configuration
`FB_ARB_FILL_EN`:
- Defined: the fill engine and arbitration are present as described.
- Undefined:
  - The fill logic and the `last` register are not built.
  - `fill_busy = 0`, `fill_done = 0`, `cpu_ready = 1` constantly.
  - `fill_*` inputs are ignored.
  - The block is a one-cycle registered pass-through of CPU writes.
- Port list is identical in both builds.

## Test plan
- Reset then idle → `fb_we = 0`, `cpu_ready = 1`, `fill_busy = 0`. CPU write addr 0x123 data 0x41 → next cycle `fb_we = 1`, `fb_addr = 0x123`, `fb_data = 0x41`.
- `fill_start`, base 0x010, count 4, value 0x20, no CPU → writes 0x010..0x013 of 0x20 in cycles 2..5, `fill_done` at cycle 5, `fill_busy` high for cycles 1..4.
- Fill base 0xFFE, count 3 → addresses 0xFFE, 0xFFF, 0x000 written. Separately, count 0 → `fill_done` pulse at cycle 1, no `fb_we`.
- Fill count 4 with `cpu_we` held high throughout → `fb_we` sequence CPU, FILL, CPU, FILL, ... (CPU first); fill completes after 8 grants; no CPU write lost or duplicated (every accepted `cpu_we && cpu_ready` appears exactly once).
- `rst` asserted mid-fill (after 2 of 10 bytes) → next cycle `fb_we = 0`, `fill_busy = 0`, no `fill_done`. `fill_start` during RUN is ignored, with the original range completed unchanged.
- Build without `FB_ARB_FILL_EN` → `fill_start` produces no writes and no `fill_done`; CPU writes pass with 1-cycle latency every cycle.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbiter between CPU stores and a fill engine onto one registered framebuffer write port (clk50, rst, cpu_*, fill_*, fb_*); fill engine and arbitration are built only with FB_ARB_FILL_EN, otherwise CPU writes pass through.
module fb_write_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_count,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_we
);
  logic              cpu_grant, fill_grant;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] val;
`ifdef FB_ARB_FILL_EN
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state, state_nx;
  logic [ADDR_W:0] rem;
  logic            last;
  always_comb begin
    fill_busy  = state == RUN;
    cpu_ready  = !fill_busy || last;
    cpu_grant  = cpu_we && cpu_ready;
    fill_grant = fill_busy && !cpu_grant;
    state_nx   = (state == IDLE) ? ((fill_start && fill_count != '0) ? RUN : IDLE)
                                 : ((fill_grant && rem == (ADDR_W+1)'(1)) ? IDLE : RUN);
  end
  always_ff @(posedge clk50) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      fill_done <= 1'b0;
      ptr       <= '0;
      rem       <= '0;
      val       <= '0;
    end else begin
      state     <= state_nx;
      fill_done <= (state == IDLE && fill_start && fill_count == '0) ||
                   (fill_grant && rem == (ADDR_W+1)'(1));
      if (state == IDLE && fill_start) begin
        ptr <= fill_base;
        rem <= fill_count;
        val <= fill_value;
      end else if (fill_grant) begin
        ptr <= ptr + ADDR_W'(1);
        rem <= rem - (ADDR_W+1)'(1);
      end
      if (cpu_we && fill_busy) last <= !cpu_grant;
    end
  end
`else
  logic unused_fill;
  assign unused_fill = ^{fill_start, fill_base, fill_count, fill_value};
  assign fill_busy   = 1'b0;
  assign fill_done   = 1'b0;
  assign cpu_ready   = 1'b1;
  assign cpu_grant   = cpu_we;
  assign fill_grant  = 1'b0;
  assign ptr         = '0;
  assign val         = '0;
`endif
  always_ff @(posedge clk50) begin
    if (rst) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= cpu_grant || fill_grant;
      if (cpu_grant || fill_grant) begin
        fb_addr <= cpu_grant ? cpu_addr : ptr;
        fb_data <= cpu_grant ? cpu_data : val;
      end
    end
  end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed and random checks of fb_write_arbiter against a cycle-level behavioural model.
module tb_fb_write_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
`ifdef FB_ARB_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  logic          clk50 = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_ready;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_base = '0;
  logic [AW:0]   fill_count = '0;
  logic [DW-1:0] fill_value = '0;
  logic          fill_busy, fill_done, fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;
  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk50(clk50), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_ready(cpu_ready), .fill_start(fill_start), .fill_base(fill_base),
    .fill_count(fill_count), .fill_value(fill_value), .fill_busy(fill_busy),
    .fill_done(fill_done), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
  );
  always #5 clk50 = ~clk50;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  bit            m_busy = 1'b0, m_done = 1'b0, m_last_fill = 1'b1, m_we = 1'b0;
  bit            m_rdy, m_cg, m_fg;
  logic [AW-1:0] m_addr = '0, m_ptr = '0;
  logic [DW-1:0] m_data = '0, m_val = '0;
  int            m_rem = 0;
  bit            chk_en = 1'b0;
  always @(posedge clk50) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_last_fill = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_rdy = !m_busy || m_last_fill;
      m_cg  = cpu_we && m_rdy;
      m_fg  = m_busy && !m_cg;
      m_we  = m_cg || m_fg;
      if (m_cg) begin
        m_addr = cpu_addr; m_data = cpu_data;
      end else if (m_fg) begin
        m_addr = m_ptr; m_data = m_val;
      end
      if (cpu_we && m_busy) m_last_fill = !m_cg;
      m_done = 1'b0;
      if (m_fg) begin
        m_ptr = m_ptr + 12'd1;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (FILL && !m_busy && fill_start) begin
        if (fill_count == '0) m_done = 1'b1;
        else begin
          m_busy = 1'b1; m_ptr = fill_base; m_rem = int'(fill_count); m_val = fill_value;
        end
      end
    end
  end
  always @(negedge clk50) begin
    if (chk_en) begin
      chk("fb_we", 32'(fb_we), 32'(m_we));
      chk("fb_addr", 32'(fb_addr), 32'(m_addr));
      chk("fb_data", 32'(fb_data), 32'(m_data));
      chk("cpu_ready", 32'(cpu_ready), 32'(!m_busy || m_last_fill));
      chk("fill_busy", 32'(fill_busy), 32'(m_busy));
      chk("fill_done", 32'(fill_done), 32'(m_done));
    end
  end
  task automatic step();
    @(posedge clk50);
    #1;
  endtask
  logic [15:0]   busy_b, we_b, done_b;
  logic [AW-1:0] addr_at [16];
  logic [DW-1:0] data_at [16];
  task automatic run_fill(input logic [AW-1:0] base, input int cnt, input logic [DW-1:0] v,
                          input int cpu_cycles);
    fill_start = 1'b1; fill_base = base; fill_count = 13'(cnt); fill_value = v;
    for (int k = 0; k < 16; k++) begin
      cpu_we = k < cpu_cycles;
      cpu_addr = 12'($urandom); cpu_data = 8'($urandom);
      @(negedge clk50);
      busy_b[k] = fill_busy; we_b[k] = fb_we; done_b[k] = fill_done;
      addr_at[k] = fb_addr; data_at[k] = fb_data;
      step();
      fill_start = 1'b0;
    end
    cpu_we = 1'b0;
  endtask
  initial begin
    int cnt_a, cnt_b;
    @(posedge clk50);
    chk_en = 1'b1;
    #1;
    step();
    rst = 1'b0;
    @(negedge clk50);
    chk("reset fb_we", 32'(fb_we), 32'd0);
    chk("reset cpu_ready", 32'(cpu_ready), 32'd1);
    chk("reset fill_busy", 32'(fill_busy), 32'd0);
    step();
    cpu_we = 1'b1; cpu_addr = 12'h123; cpu_data = 8'h41;
    step();
    cpu_we = 1'b0;
    @(negedge clk50);
    chk("cpu write we", 32'(fb_we), 32'd1);
    chk("cpu write addr", 32'(fb_addr), 32'h123);
    chk("cpu write data", 32'(fb_data), 32'h41);
    step();
    run_fill(12'h010, 4, 8'h20, 0);
    chk("fill4 busy", 32'(busy_b), FILL ? 32'h001E : 32'h0);
    chk("fill4 we", 32'(we_b), FILL ? 32'h003C : 32'h0);
    chk("fill4 done", 32'(done_b), FILL ? 32'h0020 : 32'h0);
    if (FILL) begin
      chk("fill4 first addr", 32'(addr_at[2]), 32'h010);
      chk("fill4 last addr", 32'(addr_at[5]), 32'h013);
      chk("fill4 data", 32'(data_at[5]), 32'h20);
    end
    run_fill(12'hFFE, 3, 8'h5A, 0);
    chk("wrap we", 32'(we_b), FILL ? 32'h001C : 32'h0);
    if (FILL) begin
      chk("wrap addr0", 32'(addr_at[2]), 32'hFFE);
      chk("wrap addr2", 32'(addr_at[4]), 32'h000);
    end
    run_fill(12'h300, 0, 8'h11, 0);
    chk("count0 done", 32'(done_b), FILL ? 32'h0002 : 32'h0);
    chk("count0 we", 32'(we_b), 32'h0);
    chk("count0 busy", 32'(busy_b), 32'h0);
    run_fill(12'h040, 4, 8'h77, 10);
    chk("contend busy", 32'(busy_b), FILL ? 32'h01FE : 32'h0);
    chk("contend done", 32'(done_b), FILL ? 32'h0200 : 32'h0);
    chk("contend we", 32'(we_b), 32'h07FE);
    fill_start = 1'b1; fill_base = 12'h200; fill_count = 13'd10; fill_value = 8'h99;
    step();
    fill_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk50);
    chk("abort fb_we", 32'(fb_we), 32'd0);
    chk("abort busy", 32'(fill_busy), 32'd0);
    chk("abort done", 32'(fill_done), 32'd0);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      @(negedge clk50);
      cnt_a += int'(fill_done);
      cnt_b += int'(fb_we);
    end
    chk("abort later done", 32'(cnt_a), 32'd0);
    chk("abort later we", 32'(cnt_b), 32'd0);
    step();
    fill_start = 1'b1; fill_base = 12'h100; fill_count = 13'd5; fill_value = 8'h33;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk50);
      cnt_a += int'(fill_busy);
      cnt_b += int'(fb_we && fb_addr == 12'h800);
      step();
      fill_start = k == 1;
      fill_base = 12'h800; fill_count = 13'd1; fill_value = 8'hFF;
    end
    fill_start = 1'b0;
    chk("restart busy cycles", 32'(cnt_a), FILL ? 32'd5 : 32'd0);
    chk("restart ignored", 32'(cnt_b), 32'd0);
    for (int k = 0; k < 3000; k++) begin
      rst = $urandom_range(0, 199) == 0;
      cpu_we = $urandom_range(0, 1) == 1;
      cpu_addr = 12'($urandom); cpu_data = 8'($urandom);
      fill_start = $urandom_range(0, 19) == 0;
      fill_base = 12'($urandom);
      fill_count = 13'($urandom_range(0, 8));
      fill_value = 8'($urandom);
      step();
    end
    rst = 1'b0; cpu_we = 1'b0; fill_start = 1'b0;
    repeat (12) step();
    @(negedge clk50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
